// File: rtl/isqrt_arb_pkg.sv
// Shared types and widths for the two-requester isqrt arbiter.
package isqrt_arb_pkg;

    localparam int unsigned X_W   = 32;
    localparam int unsigned Y_W   = 16;
    localparam int unsigned ID_W  = 1;
    localparam int unsigned CNT_W = 5;

    typedef logic [ID_W-1:0] req_id_t;

    typedef enum logic [ID_W-1:0] {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_id_e;

    // Operand issued to the shared unit together with its owner
    typedef struct packed {
        req_id_e        id;
        logic [X_W-1:0] x;
    } issue_t;

endpackage

// File: rtl/isqrt_tag_fifo.sv
// In-order FIFO of requester ids matching results back to their owners.
module isqrt_tag_fifo
    import isqrt_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  req_id_e push_id,
    input  logic    pop,
    output logic    full,
    output logic    empty,
    output req_id_e head
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    req_id_e         mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            do_push;
    logic            do_pop;

    // Pointers wrap at DEPTH, not at the next power of two
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Status and qualified push/pop
    always_comb begin
        full    = (count == CW'(DEPTH));
        empty   = (count == '0);
        do_push = push && !full;
        do_pop  = pop && !empty;
        head    = mem[rd_ptr];
    end

    // Pointer, occupancy and storage update
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= REQ0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_id;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/isqrt_shared_arbiter.sv
// Round-robin sharing of one in-order isqrt unit between two requesters.
module isqrt_shared_arbiter
    import isqrt_arb_pkg::*;
#(
    parameter int unsigned MAX_INFLIGHT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_vld,
    input  logic [X_W-1:0]   req0_x,
    output logic             req0_rdy,
    input  logic             req1_vld,
    input  logic [X_W-1:0]   req1_x,
    output logic             req1_rdy,
    output logic             rsp0_vld,
    output logic [Y_W-1:0]   rsp0_y,
    output logic             rsp1_vld,
    output logic [Y_W-1:0]   rsp1_y,
    output logic             isqrt_x_vld,
    output logic [X_W-1:0]   isqrt_x,
    input  logic             isqrt_y_vld,
    input  logic [Y_W-1:0]   isqrt_y,
    output logic [CNT_W-1:0] inflight,
    output logic             err_orphan
);

    req_id_e last_grant;
    logic    full_c;
    logic    grant0_c;
    logic    grant1_c;
    logic    accept_c;
    logic    pop_c;
    logic    orphan_c;
    issue_t  issue_c;
    logic    fifo_full;
    logic    fifo_empty;
    req_id_e head_id;

    // Arbitration against the registered occupancy; a same-cycle pop frees nothing
    always_comb begin
        full_c     = (inflight >= CNT_W'(MAX_INFLIGHT)) || fifo_full;
        grant0_c   = req0_vld && (!req1_vld || (last_grant == REQ1));
        grant1_c   = req1_vld && (!req0_vld || (last_grant == REQ0));
        req0_rdy   = grant0_c && !full_c;
        req1_rdy   = grant1_c && !full_c;
        accept_c   = req0_rdy || req1_rdy;
        issue_c.id = req1_rdy ? REQ1 : REQ0;
        issue_c.x  = req1_rdy ? req1_x : req0_x;
        pop_c      = isqrt_y_vld && !fifo_empty;
        orphan_c   = isqrt_y_vld && fifo_empty;
    end

    isqrt_tag_fifo #(
        .DEPTH (MAX_INFLIGHT)
    ) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (accept_c),
        .push_id (issue_c.id),
        .pop     (pop_c),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (head_id)
    );

    // Grant pointer moves only when a request is actually taken
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= REQ1;
        end else if (accept_c) begin
            last_grant <= issue_c.id;
        end
    end

    // Issue strobe and operand to the shared unit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            isqrt_x_vld <= 1'b0;
            isqrt_x     <= '0;
        end else begin
            isqrt_x_vld <= accept_c;
            if (accept_c) begin
                isqrt_x <= issue_c.x;
            end
        end
    end

    // Route each result to the owner recorded at the FIFO head
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp0_vld <= 1'b0;
            rsp0_y   <= '0;
            rsp1_vld <= 1'b0;
            rsp1_y   <= '0;
        end else begin
            rsp0_vld <= pop_c && (head_id == REQ0);
            rsp1_vld <= pop_c && (head_id == REQ1);
            if (pop_c && (head_id == REQ0)) begin
                rsp0_y <= isqrt_y;
            end
            if (pop_c && (head_id == REQ1)) begin
                rsp1_y <= isqrt_y;
            end
        end
    end

    // Outstanding count and sticky orphan-result flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight   <= '0;
            err_orphan <= 1'b0;
        end else begin
            case ({accept_c, pop_c})
                2'b10:   inflight <= inflight + CNT_W'(1);
                2'b01:   inflight <= inflight - CNT_W'(1);
                default: inflight <= inflight;
            endcase
            if (orphan_c) begin
                err_orphan <= 1'b1;
            end
        end
    end

endmodule

// File: doc/isqrt_shared_arbiter.md
ISQRT_SHARED_ARBITER -- requirements
Module: isqrt_shared_arbiter

Interface
REQ-001 The module SHALL have parameter MAX_INFLIGHT, default 4, giving the maximum number of requests outstanding in the isqrt unit (range 1..16).
REQ-002 The module SHALL have ports, clock and reset first:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- req0_vld  in  1  requester 0 operand valid
- req0_x  in  32  requester 0 operand
- req0_rdy  out  1  requester 0 accepted this cycle
- req1_vld  in  1  requester 1 operand valid
- req1_x  in  32  requester 1 operand
- req1_rdy  out  1  requester 1 accepted this cycle
- rsp0_vld  out  1  result valid for requester 0
- rsp0_y  out  16  result for requester 0
- rsp1_vld  out  1  result valid for requester 1
- rsp1_y  out  16  result for requester 1
- isqrt_x_vld  out  1  issue strobe to shared isqrt
- isqrt_x  out  32  operand to shared isqrt
- isqrt_y_vld  in  1  isqrt result valid
- isqrt_y  in  16  isqrt result
- inflight  out  5  count of outstanding requests
- err_orphan  out  1  sticky: result arrived with nothing outstanding

Function
REQ-003 A request k SHALL be accepted in the cycle where reqk_vld and reqk_rdy are both 1; at most one of req0_rdy/req1_rdy SHALL be 1 per cycle.
REQ-004 reqk_rdy SHALL be combinational: 1 only if reqk_vld is 1, inflight < MAX_INFLIGHT, and k wins arbitration.
REQ-005 Arbitration SHALL be round-robin: one requester valid -> it wins; both valid -> the one not granted last wins; after reset requester 0 has priority.
REQ-006 The last-granted pointer SHALL update only on an acceptance.
REQ-007 Acceptance in cycle T SHALL produce isqrt_x_vld=1 and isqrt_x=accepted operand in cycle T+1 (registered); otherwise isqrt_x_vld=0 and isqrt_x holds its last value.
REQ-008 On acceptance the requester id SHALL be pushed into an in-order tag FIFO of depth MAX_INFLIGHT; the isqrt unit is in-order.
REQ-009 On isqrt_y_vld=1 with a non-empty tag FIFO, the head tag SHALL be popped and, in the next cycle, rspN_vld=1 and rspN_y=isqrt_y SHALL be driven for that tag only; rsp_y holds otherwise.
REQ-010 Requesters SHALL have no response backpressure; each response strobe lasts exactly one cycle.
REQ-011 inflight SHALL increment on acceptance, decrement on non-orphan isqrt_y_vld, and stay unchanged when both happen in the same cycle.
REQ-012 The full check SHALL use the registered inflight value; a same-cycle pop SHALL NOT free a slot for a same-cycle acceptance.
REQ-013 isqrt_y_vld with an empty tag FIFO SHALL be ignored (no response, no count change) and SHALL set err_orphan until reset.
REQ-014 Tag FIFO pointers SHALL wrap modulo MAX_INFLIGHT without losing order.

Reset
REQ-015 Asserting rst low SHALL immediately clear: isqrt_x_vld, rsp0_vld, rsp1_vld, inflight, err_orphan, FIFO pointers; set last-granted so requester 0 has priority; isqrt_x, rsp0_y and rsp1_y SHALL reset to 0.
REQ-016 Reset mid-operation SHALL discard all outstanding tags; results arriving after reset release SHALL be treated as orphans.

Structure
REQ-017 A shared package isqrt_arb_pkg SHALL hold the requester-id type (1 bit), the enum REQ0/REQ1, and the operand/result width constants (32/16).
REQ-018 The tag FIFO SHALL be the sub-module isqrt_tag_fifo (push, pop, full, empty, head), instantiated once.

Verification
REQ-019 Single request: req0_x=16 at cycle 0 -> req0_rdy=1 at cycle 0, isqrt_x_vld with 16 at cycle 1; model returns 4 -> rsp0_vld, rsp0_y=4, rsp1_vld=0.
REQ-020 Contention: both valid continuously with req0_x=25, req1_x=100 -> grants alternate 0,1,0,1; responses 5 and 10 routed to rsp0/rsp1 in the same alternating order.
REQ-021 Full: MAX_INFLIGHT=4, model latency 10, req1 held valid with 0xFFFFFFFF -> exactly 4 acceptances, rdy=0 until first result; all four rsp1_y=65535.
REQ-022 Simultaneous pop and push at inflight=4: no acceptance that cycle; inflight goes 4->3, acceptance next cycle returns it to 4.
REQ-023 Orphan: isqrt_y_vld=1 with no requests -> no rsp strobe, inflight=0, err_orphan=1 until rst low.
REQ-024 Reset mid-flight: 3 outstanding, rst low for 2 cycles -> inflight=0 immediately; a late isqrt_y_vld sets err_orphan and produces no response.
